hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the SELEN core. It generates the hold enables and flush strobes for the fetch, decode, execute and memory stage registers. It also generates the execute-stage operand forwarding selects. It sequences load-use bubbles, taken-branch squashes, and instruction/data memory wait stalls through a small state machine. It keeps a saturating stall-cycle counter. The block sits beside the pipeline registers and drives their `enb*`/`flash*` inputs directly.

## Interface
- `CNT_W`, default 16, width of the stall-cycle counter.

- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `rs1D`, `rs2D`  in  5 each  source registers of the instruction in decode
- `rs1E`, `rs2E`  in  5 each  source registers of the instruction in execute
- `rdE`, `rdM`, `rdW`  in  5 each  destination registers in execute / memory / writeback
- `we_regE`, `we_regM`, `we_regW`  in  1 each  register write enables of those stages
- `ld_E`  in  1  instruction in execute is a load
- `brch_takenE`  in  1  branch/jump in execute resolved taken
- `imem_rdy`  in  1  instruction memory has valid data this cycle
- `dmem_req`  in  1  memory stage issues a data access
- `dmem_ack`  in  1  data access completes this cycle
- `enbF`, `enbD`, `enbE`, `enbM`  out  1 each  stage-register hold; 1 = hold the current contents
- `flashD`, `flashE`  out  1 each  clear the decode / execute register to a bubble at the next edge
- `fwd_aE`, `fwd_bE`  out  2 each  operand select: 00 register file, 01 from memory stage, 10 from writeback
- `stall_cnt`  out  CNT_W  saturating count of decode-hold cycles

## Operation
- FSM states: RUN, LDSTALL, DWAIT, IWAIT. The state is registered. All outputs except `stall_cnt` are combinational from the state and the current inputs.
- Definitions:
  - `mem_stall` = `dmem_req & !dmem_ack`.
  - `ld_use` = `ld_E & we_regE & rdE!=0 & (rdE==rs1D | rdE==rs2D)`.
- Event priority, highest first: `rst` > `mem_stall` > `brch_takenE` > `ld_use` (RUN only) > `!imem_rdy`.
- `mem_stall`:
  - Outputs: `enbF`=`enbD`=`enbE`=`enbM`=1, no flash.
  - Next state is DWAIT.
  - DWAIT persists while `mem_stall` holds. The cycle `dmem_ack`=1 releases all holds, and the next state is RUN.
- Taken branch, when no `mem_stall`:
  - Outputs: `flashD`=`flashE`=1, no holds.
  - Next state is RUN.
  - A branch raised during a memory stall stays held in execute and is acted on in the release cycle.
- `ld_use` in RUN:
  - Outputs: `enbF`=`enbD`=1, `flashE`=1.
  - Next state is LDSTALL.
  - LDSTALL suppresses the `ld_use` check for one cycle, then goes unconditionally to RUN (or to DWAIT/IWAIT by priority).
- `!imem_rdy`:
  - Outputs: `enbF`=1, `flashD`=1. The back end keeps draining.
  - Next state is IWAIT. IWAIT returns to RUN in the cycle `imem_rdy`=1.
  - A taken branch in IWAIT behaves as above, and the state stays IWAIT until `imem_rdy`.
- Forwarding, evaluated independently for `rs1E` (→ `fwd_aE`) and `rs2E` (→ `fwd_bE`):
  - 01 if `we_regM & rdM!=0 & rdM==rsE`.
  - Else 10 if `we_regW & rdW!=0 & rdW==rsE`.
  - Else 00.
  - The memory stage wins when both match. x0 is never forwarded.
- `stall_cnt` increments by 1 at each edge where `enbD`=1. It saturates at all-ones and does not wrap.

## Timing
- `rst` high: the next state is RUN and `stall_cnt` becomes 0. During `rst`, outputs are forced to: all `enb*`=0, `flashD`=`flashE`=1, `fwd_*`=00.
- `rst` asserted mid-stall (DWAIT, LDSTALL, IWAIT) abandons the stall. The first cycle after `rst` falls is RUN with no holds.
- Load-use costs exactly 1 bubble. The load reaches writeback in time to be forwarded via `fwd`=10 to the dependent instruction.
- A memory stall of N wait cycles holds all stages for N cycles. The release is the same cycle as `dmem_ack`.
- Branch penalty is 2 bubbles: the decode and execute registers are cleared at the edge after `brch_takenE`.
- Simultaneous `ld_use` and `brch_takenE`: the branch wins, and the load-use instruction is squashed with no bubble.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding operates as described above.
- `HAZARD_FWD_EN` not defined:
  - `fwd_aE`/`fwd_bE` are constant 00.
  - Any decode source matching a writing `rdE` or `rdM` (rd≠0) forces `enbF`=`enbD`=1 and `flashE`=1, repeating until no match remains.
  - The register file is write-through, so `rdW` is not checked.
  - This RAW stall has the same priority slot as `ld_use` and replaces it.

## Test plan
- Load x5 then `add x6,x5,x1`: 1 cycle with `enbF`=`enbD`=`flashE`=1. Next cycle `fwd_aE`=10. `stall_cnt`=1.
- `dmem_req`=1 with `dmem_ack` low for 3 cycles: all four `enb*`=1 for 3 cycles, released in the ack cycle. `stall_cnt`+=3.
- `brch_takenE`=1 together with `ld_use`: `flashD`=`flashE`=1, `enbD`=0, next state RUN.
- `rdM`=`rdW`=7, `rs1E`=7, both writing: `fwd_aE`=01. Same with `rdM`=0: `fwd_aE`=10. `rs2E`=0: `fwd_bE`=00.
- `rst` asserted in DWAIT: the next cycle after release has no holds and `stall_cnt`=0. Preload the counter near saturation: it stops at 0xFFFF.
- Without `HAZARD_FWD_EN`, an ALU result in x3 followed by `sub x4,x3,x2`: 2 stall cycles, `fwd_*` stays 00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// SELEN pipeline hazard controller: holds, flushes, forwarding and stall count.
// Build option HAZARD_FWD_EN enables operand forwarding; otherwise RAW stalls.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [4:0]       rs1E,
   input  logic [4:0]       rs2E,
   input  logic [4:0]       rdE,
   input  logic [4:0]       rdM,
   input  logic [4:0]       rdW,
   input  logic             we_regE,
   input  logic             we_regM,
   input  logic             we_regW,
   input  logic             ld_E,
   input  logic             brch_takenE,
   input  logic             imem_rdy,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             enbF,
   output logic             enbD,
   output logic             enbE,
   output logic             enbM,
   output logic             flashD,
   output logic             flashE,
   output logic [1:0]       fwd_aE,
   output logic [1:0]       fwd_bE,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN,
      LDSTALL,
      DWAIT,
      IWAIT
   } state_t;

   state_t state;
   state_t state_nx;
   logic   mem_stall;
   logic   raw_hz;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   assign mem_stall = dmem_req & ~dmem_ack;

`ifdef HAZARD_FWD_EN
   logic ld_use;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       we_m,
      input logic [4:0] rd_m,
      input logic       we_w,
      input logic [4:0] rd_w
   );
      if (we_m && rd_m != 5'd0 && rd_m == rs)
         return 2'b01;
      else if (we_w && rd_w != 5'd0 && rd_w == rs)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign ld_use = ld_E & we_regE & (rdE != 5'd0) &
                   ((rdE == rs1D) | (rdE == rs2D));
   assign raw_hz = ld_use & (state == RUN);
   assign fwd_a  = fwd_sel(rs1E, we_regM, rdM, we_regW, rdW);
   assign fwd_b  = fwd_sel(rs2E, we_regM, rdM, we_regW, rdW);
`else
   logic dep_e;
   logic dep_m;
   logic unused;

   // Write-through register file: a writeback producer is already visible.
   assign dep_e  = we_regE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
   assign dep_m  = we_regM & (rdM != 5'd0) & ((rdM == rs1D) | (rdM == rs2D));
   assign raw_hz = (dep_e | dep_m) & ((state == RUN) | (state == LDSTALL));
   assign fwd_a  = 2'b00;
   assign fwd_b  = 2'b00;
   assign unused = ^{rs1E, rs2E, rdW, we_regW, ld_E};
`endif

   always_comb begin
      enbF     = 1'b0;
      enbD     = 1'b0;
      enbE     = 1'b0;
      enbM     = 1'b0;
      flashD   = 1'b0;
      flashE   = 1'b0;
      fwd_aE   = fwd_a;
      fwd_bE   = fwd_b;
      state_nx = RUN;
      if (rst) begin
         flashD = 1'b1;
         flashE = 1'b1;
         fwd_aE = 2'b00;
         fwd_bE = 2'b00;
      end else if (mem_stall) begin
         enbF     = 1'b1;
         enbD     = 1'b1;
         enbE     = 1'b1;
         enbM     = 1'b1;
         state_nx = DWAIT;
      end else if (brch_takenE) begin
         flashD = 1'b1;
         flashE = 1'b1;
         if (state == IWAIT && !imem_rdy)
            state_nx = IWAIT;
      end else if (raw_hz) begin
         enbF     = 1'b1;
         enbD     = 1'b1;
         flashE   = 1'b1;
         state_nx = LDSTALL;
      end else if (!imem_rdy) begin
         enbF     = 1'b1;
         flashD   = 1'b1;
         state_nx = IWAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         if (enbD && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; follows HAZARD_FWD_EN if defined.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic we_regE, we_regM, we_regW, ld_E, brch_takenE;
   logic imem_rdy, dmem_req, dmem_ack;
   logic enbF, enbD, enbE, enbM, flashD, flashE;
   logic [1:0] fwd_aE, fwd_bE;
   logic [15:0] stall_cnt;
   logic s_enbF, s_enbD, s_enbE, s_enbM, s_flashD, s_flashE;
   logic [1:0] s_fwd_aE, s_fwd_bE;
   logic [3:0] cnt_s;

   int n_run = 0;
   int n_fail = 0;
   int exp_cnt = 0;

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LD   = 6'b110001;
   localparam logic [5:0] C_MEM  = 6'b111100;
   localparam logic [5:0] C_BR   = 6'b000011;
   localparam logic [5:0] C_IF   = 6'b100010;
`ifdef HAZARD_FWD_EN
   localparam logic [1:0] FM = 2'b01;
   localparam logic [1:0] FW = 2'b10;
`else
   localparam logic [1:0] FM = 2'b00;
   localparam logic [1:0] FW = 2'b00;
`endif

   wire [5:0] ctl = {enbF, enbD, enbE, enbM, flashD, flashE};

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
      .rdE(rdE), .rdM(rdM), .rdW(rdW),
      .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
      .ld_E(ld_E), .brch_takenE(brch_takenE), .imem_rdy(imem_rdy),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .enbF(enbF), .enbD(enbD), .enbE(enbE), .enbM(enbM),
      .flashD(flashD), .flashE(flashE),
      .fwd_aE(fwd_aE), .fwd_bE(fwd_bE), .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
      .rdE(rdE), .rdM(rdM), .rdW(rdW),
      .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
      .ld_E(ld_E), .brch_takenE(brch_takenE), .imem_rdy(imem_rdy),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .enbF(s_enbF), .enbD(s_enbD), .enbE(s_enbE), .enbM(s_enbM),
      .flashD(s_flashD), .flashE(s_flashE),
      .fwd_aE(s_fwd_aE), .fwd_bE(s_fwd_bE), .stall_cnt(cnt_s)
   );

   task automatic idle;
      rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
      rdE = 0; rdM = 0; rdW = 0;
      we_regE = 0; we_regM = 0; we_regW = 0;
      ld_E = 0; brch_takenE = 0; imem_rdy = 1;
      dmem_req = 0; dmem_ack = 0;
   endtask

   task automatic ld_pat;
      idle;
      ld_E = 1; we_regE = 1; rdE = 5; rs1D = 5; rs2D = 1;
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic test_reset;
      idle;
      rst = 1; dmem_req = 1; rs1E = 7; rdM = 7; we_regM = 1;
      mid;
      n_run++;
      if (ctl !== C_RST_V()) begin
         n_fail++;
         $display("FAIL rst_ctl got=%b exp=%b", ctl, C_BR);
      end
      n_run++;
      if (fwd_aE !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_fwd got=%b exp=00", fwd_aE);
      end
      cyc;
      idle; rst = 0;
      mid;
      n_run++;
      if (ctl !== C_NONE || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_after ctl=%b cnt=%0d exp=%b/0", ctl, stall_cnt, C_NONE);
      end
      exp_cnt = 0;
      cyc;
   endtask

   function automatic logic [5:0] C_RST_V();
      return C_BR;
   endfunction

   task automatic test_load_use;
      ld_pat;
      mid;
      n_run++;
      if (ctl !== C_LD) begin
         n_fail++;
         $display("FAIL lu_bubble got=%b exp=%b", ctl, C_LD);
      end
      exp_cnt++;
      cyc;
      idle; rdM = 5; we_regM = 1; rs1D = 5; rs2D = 1;
      mid;
`ifdef HAZARD_FWD_EN
      n_run++;
      if (ctl !== C_NONE) begin
         n_fail++;
         $display("FAIL lu_release got=%b exp=%b", ctl, C_NONE);
      end
`else
      n_run++;
      if (ctl !== C_LD) begin
         n_fail++;
         $display("FAIL lu_raw_m got=%b exp=%b", ctl, C_LD);
      end
      exp_cnt++;
`endif
      cyc;
      idle; rdW = 5; we_regW = 1; rs1E = 5; rs2E = 1;
      mid;
      n_run++;
      if (fwd_aE !== FW || fwd_bE !== 2'b00 || ctl !== C_NONE) begin
         n_fail++;
         $display("FAIL lu_fwd a=%b b=%b ctl=%b exp=%b/00/%b",
                  fwd_aE, fwd_bE, ctl, FW, C_NONE);
      end
      n_run++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
      end
      cyc;
   endtask

   task automatic test_mem_stall;
      for (int i = 0; i < 3; i++) begin
         idle; dmem_req = 1; brch_takenE = (i == 2);
         mid;
         n_run++;
         if (ctl !== C_MEM) begin
            n_fail++;
            $display("FAIL mem_hold%0d got=%b exp=%b", i, ctl, C_MEM);
         end
         exp_cnt++;
         cyc;
      end
      idle; dmem_req = 1; dmem_ack = 1; brch_takenE = 1;
      mid;
      n_run++;
      if (ctl !== C_BR) begin
         n_fail++;
         $display("FAIL mem_release_br got=%b exp=%b", ctl, C_BR);
      end
      cyc;
      ld_pat;
      mid;
      n_run++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL mem_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
      end
      n_run++;
      if (ctl !== C_LD) begin
         n_fail++;
         $display("FAIL mem_to_run got=%b exp=%b", ctl, C_LD);
      end
      exp_cnt++;
      cyc;
      idle;
      mid;
      cyc;
   endtask

   task automatic test_branch_ld_use;
      ld_pat; brch_takenE = 1;
      mid;
      n_run++;
      if (ctl !== C_BR) begin
         n_fail++;
         $display("FAIL br_over_lu got=%b exp=%b", ctl, C_BR);
      end
      cyc;
      ld_pat;
      mid;
      n_run++;
      if (ctl !== C_LD) begin
         n_fail++;
         $display("FAIL br_next_run got=%b exp=%b", ctl, C_LD);
      end
      exp_cnt++;
      cyc;
      idle;
      mid;
      n_run++;
      if (ctl !== C_NONE || stall_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL br_after ctl=%b cnt=%0d exp=%b/%0d",
                  ctl, stall_cnt, C_NONE, exp_cnt);
      end
      cyc;
   endtask

   task automatic test_forward;
      idle;
      we_regM = 1; we_regW = 1; rdM = 7; rdW = 7; rs1E = 7; rs2E = 0;
      #1;
      n_run++;
      if (fwd_aE !== FM || fwd_bE !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_mem a=%b b=%b exp=%b/00", fwd_aE, fwd_bE, FM);
      end
      rdM = 0;
      #1;
      n_run++;
      if (fwd_aE !== FW) begin
         n_fail++;
         $display("FAIL fwd_wb got=%b exp=%b", fwd_aE, FW);
      end
      rdM = 7; we_regM = 0;
      #1;
      n_run++;
      if (fwd_aE !== FW) begin
         n_fail++;
         $display("FAIL fwd_m_nowe got=%b exp=%b", fwd_aE, FW);
      end
      we_regM = 1; rdM = 0; rdW = 0; rs1E = 0;
      #1;
      n_run++;
      if (fwd_aE !== 2'b00 || fwd_bE !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_x0 a=%b b=%b exp=00/00", fwd_aE, fwd_bE);
      end
      rs2E = 9; rdW = 9;
      #1;
      n_run++;
      if (fwd_bE !== FW || fwd_aE !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_b_wb b=%b a=%b exp=%b/00", fwd_bE, fwd_aE, FW);
      end
      rdM = 9;
      #1;
      n_run++;
      if (fwd_bE !== FM) begin
         n_fail++;
         $display("FAIL fwd_b_mem got=%b exp=%b", fwd_bE, FM);
      end
      cyc;
   endtask

   task automatic test_imem;
      idle; imem_rdy = 0;
      mid;
      n_run++;
      if (ctl !== C_IF) begin
         n_fail++;
         $display("FAIL if_wait got=%b exp=%b", ctl, C_IF);
      end
      cyc;
      idle; imem_rdy = 0; brch_takenE = 1;
      mid;
      n_run++;
      if (ctl !== C_BR) begin
         n_fail++;
         $display("FAIL if_branch got=%b exp=%b", ctl, C_BR);
      end
      cyc;
      idle; imem_rdy = 0;
      mid;
      n_run++;
      if (ctl !== C_IF) begin
         n_fail++;
         $display("FAIL if_wait2 got=%b exp=%b", ctl, C_IF);
      end
      cyc;
      idle;
      mid;
      n_run++;
      if (ctl !== C_NONE || stall_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL if_done ctl=%b cnt=%0d exp=%b/%0d",
                  ctl, stall_cnt, C_NONE, exp_cnt);
      end
      cyc;
   endtask

   task automatic test_raw_alu;
      idle; we_regE = 1; rdE = 3; rs1D = 3; rs2D = 2;
      mid;
`ifdef HAZARD_FWD_EN
      n_run++;
      if (ctl !== C_NONE) begin
         n_fail++;
         $display("FAIL alu_nostall got=%b exp=%b", ctl, C_NONE);
      end
      cyc;
      idle; we_regM = 1; rdM = 3; rs1E = 3; rs2E = 2;
      mid;
      n_run++;
      if (fwd_aE !== 2'b01 || fwd_bE !== 2'b00 || ctl !== C_NONE) begin
         n_fail++;
         $display("FAIL alu_fwd a=%b b=%b ctl=%b exp=01/00/%b",
                  fwd_aE, fwd_bE, ctl, C_NONE);
      end
      cyc;
`else
      n_run++;
      if (ctl !== C_LD || fwd_aE !== 2'b00) begin
         n_fail++;
         $display("FAIL raw_e ctl=%b fwd=%b exp=%b/00", ctl, fwd_aE, C_LD);
      end
      exp_cnt++;
      cyc;
      idle; we_regM = 1; rdM = 3; rs1D = 3; rs2D = 2;
      mid;
      n_run++;
      if (ctl !== C_LD) begin
         n_fail++;
         $display("FAIL raw_m got=%b exp=%b", ctl, C_LD);
      end
      exp_cnt++;
      cyc;
      idle; we_regW = 1; rdW = 3; rs1D = 3; rs2D = 2; rs1E = 3;
      mid;
      n_run++;
      if (ctl !== C_NONE || fwd_aE !== 2'b00 ||
          stall_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL raw_w ctl=%b fwd=%b cnt=%0d exp=%b/00/%0d",
                  ctl, fwd_aE, stall_cnt, C_NONE, exp_cnt);
      end
      cyc;
`endif
   endtask

   task automatic test_rst_in_dwait;
      idle; dmem_req = 1;
      mid;
      cyc;
      idle; rst = 1; dmem_req = 1;
      mid;
      n_run++;
      if (ctl !== C_BR) begin
         n_fail++;
         $display("FAIL rstd_force got=%b exp=%b", ctl, C_BR);
      end
      cyc;
      idle; rst = 0;
      mid;
      n_run++;
      if (ctl !== C_NONE || stall_cnt !== 16'd0 || cnt_s !== 4'd0) begin
         n_fail++;
         $display("FAIL rstd_after ctl=%b cnt=%0d cnt_s=%0d exp=%b/0/0",
                  ctl, stall_cnt, cnt_s, C_NONE);
      end
      exp_cnt = 0;
      cyc;
      ld_pat;
      mid;
      n_run++;
      if (ctl !== C_LD) begin
         n_fail++;
         $display("FAIL rstd_run got=%b exp=%b", ctl, C_LD);
      end
      exp_cnt++;
      cyc;
      idle;
      mid;
      cyc;
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 20; i++) begin
         idle; dmem_req = 1;
         mid;
         if (i == 10) begin
            n_run++;
            if (cnt_s !== 4'd11) begin
               n_fail++;
               $display("FAIL sat_count got=%0d exp=11", cnt_s);
            end
         end
         exp_cnt++;
         cyc;
      end
      idle;
      mid;
      n_run++;
      if (cnt_s !== 4'hF) begin
         n_fail++;
         $display("FAIL sat_hold got=%0d exp=15", cnt_s);
      end
      n_run++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL sat_wide got=%0d exp=%0d", stall_cnt, exp_cnt);
      end
      cyc;
   endtask

   initial begin
      idle;
      rst = 1;
      test_reset;
      test_load_use;
      test_mem_stall;
      test_branch_ld_use;
      test_forward;
      test_imem;
      test_raw_alu;
      test_rst_in_dwait;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
